hdmi_tx_period_ctrl: RTL and testbench
======================================

Name: hdmi_tx_period_ctrl

Overview:
Pixel-clock timing and period scheduler for the HDMI/DVI transmitter. Generates raster counters, sync, and data enable. Tells the three TMDS encoder/serializer lanes which period to emit each pixel clock: control, video preamble, video guard band, or active video. Sits upstream of the per-channel TMDS encoders that feed the 10:1 serializers.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels); must be >= 12
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, 1 = hsync active-high, 0 = active-low
VSYNC_POL, 0, 1 = vsync active-high, 0 = active-low
CNT_W, 12, width of h_cnt and v_cnt

Ports:
pixclk  input  1  pixel clock; the only clock
reset  input  1  asynchronous, active-high reset
hdmi_mode  input  1  1 = HDMI (insert preamble and guard band); 0 = DVI (control periods only)
h_cnt  output  CNT_W  horizontal position, 0..H_TOTAL-1
v_cnt  output  CNT_W  vertical position, 0..V_TOTAL-1
de  output  1  active video
hsync  output  1  horizontal sync at the configured polarity
vsync  output  1  vertical sync at the configured polarity
mode  output  2  00 control, 01 video preamble, 10 video guard band, 11 active video
ctl  output  4  CTL3..CTL0 for channels 1/2, valid while mode=00 or 01
frame_start  output  1  one-cycle pulse at h_cnt=0, v_cnt=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line order: active, FP, sync, BP. Frame order is the same in lines.
- h_cnt increments every pixclk and wraps from H_TOTAL-1 to 0. On that wrap, v_cnt increments and wraps from V_TOTAL-1 to 0.
- All outputs are registered and aligned to h_cnt/v_cnt in the same cycle. Decode uses next-state counter values; there is no extra latency.
- de = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE). When de=1, mode=11.
- hsync is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- vsync is active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. vsync changes only at h_cnt=0.
- A line is "pre-active" when the following line is active, i.e. v_cnt < V_ACTIVE-1 or v_cnt = V_TOTAL-1.
- When HDMI mode is latched and the line is pre-active:
  - h_cnt in [H_TOTAL-10, H_TOTAL-3]: mode=01, ctl=0001 (CTL0=1).
  - h_cnt in [H_TOTAL-2, H_TOTAL-1]: mode=10, ctl=0000.
- All other blanking cycles: mode=00, ctl=0000.
- hdmi_mode is sampled into an internal latch only on the h_cnt wrap to 0. Mid-line changes take effect on the next line and never alter the current line's periods.
- Reset (asynchronous, immediate) sets:
  - h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1
  - de=0, mode=00, ctl=0000, frame_start=0
  - hsync and vsync at their inactive levels
  - HDMI latch=0
- First cycle after reset deassertion: h_cnt=0, v_cnt=0, de=1, mode=11, frame_start=1. Line 0 of the first frame therefore has no preamble or guard band.
- Reset asserted mid-frame forces the reset values within the same cycle, regardless of pixclk.

Test Plan:
1. Release reset with defaults -> next cycle h=0, v=0, de=1, mode=11, frame_start=1. de stays high for 640 cycles and falls at h=640.
2. Run one line -> hsync low for h=656..751 (96 cycles). Line period is 800 cycles. frame_start is pulsed only once.
3. hdmi_mode=1 held, line v=0 -> h=790..797 mode=01, ctl=0001; h=798..799 mode=10, ctl=0000. Line v=479 has mode=00 through all of blanking. Line v=524 carries preamble and guard band.
4. Full frame -> vsync low on lines 490..491. frame_start pulses are spaced 420000 cycles apart.
5. Toggle hdmi_mode 1->0 at v=10, h=300 -> line 10 still has preamble at h=790. Line 11 onward has mode=00 through all of blanking.
6. Assert reset at v=200, h=100 mid-cycle -> outputs go to reset values before the next pixclk edge. After release, timing restarts at h=0, v=0 with frame_start=1.

Source files
------------

// File: rtl/hdmi_tx_period_ctrl.sv
// Pixel-clock raster timing and TMDS period scheduler for the HDMI/DVI transmitter.
// Every output is registered from a decode of the next-cycle counters, so outputs line up with h_cnt/v_cnt.
module hdmi_tx_period_ctrl #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CNT_W     = 12
) (
    input  logic             pixclk,
    input  logic             reset,
    input  logic             hdmi_mode,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [1:0]       mode,
    output logic [3:0]       ctl,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_DE_END     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_DE_END     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_PRE_LAST   = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_PRE_START  = CNT_W'(H_TOTAL - 10);
    localparam logic [CNT_W-1:0] H_GB_START   = CNT_W'(H_TOTAL - 2);

    typedef enum logic [1:0] {
        PERIOD_CTRL     = 2'b00,
        PERIOD_PREAMBLE = 2'b01,
        PERIOD_GUARD    = 2'b10,
        PERIOD_VIDEO    = 2'b11
    } period_t;

    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_wrap;
    logic             hdmi_lat;
    logic             hdmi_lat_nxt;
    logic             pre_active;
    logic             de_nxt;
    logic             hsync_nxt;
    logic             vsync_nxt;
    logic             fs_nxt;
    period_t          mode_nxt;
    logic [3:0]       ctl_nxt;

    // The HDMI enable is only sampled at the line boundary so a line never mixes period plans.
    always_comb begin
        h_wrap       = (h_cnt == H_LAST);
        h_nxt        = h_wrap ? '0 : h_cnt + 1'b1;
        v_nxt        = v_cnt;
        if (h_wrap) begin
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
        hdmi_lat_nxt = h_wrap ? hdmi_mode : hdmi_lat;
    end

    always_comb begin
        pre_active = (v_nxt < V_PRE_LAST) || (v_nxt == V_LAST);
        de_nxt     = (h_nxt < H_DE_END) && (v_nxt < V_DE_END);
        hsync_nxt  = ((h_nxt >= H_SYNC_START) && (h_nxt < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_nxt  = ((v_nxt >= V_SYNC_START) && (v_nxt < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
        fs_nxt     = (h_nxt == '0) && (v_nxt == '0);
        mode_nxt   = PERIOD_CTRL;
        ctl_nxt    = 4'b0000;
        if (de_nxt) begin
            mode_nxt = PERIOD_VIDEO;
        end else if (hdmi_lat_nxt && pre_active) begin
            // Preamble and guard band occupy the last 10 pixels of the line before active video.
            if (h_nxt >= H_GB_START) begin
                mode_nxt = PERIOD_GUARD;
            end else if (h_nxt >= H_PRE_START) begin
                mode_nxt = PERIOD_PREAMBLE;
                ctl_nxt  = 4'b0001;
            end
        end
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            hdmi_lat    <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            mode        <= PERIOD_CTRL;
            ctl         <= 4'b0000;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hdmi_lat    <= hdmi_lat_nxt;
            de          <= de_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            mode        <= mode_nxt;
            ctl         <= ctl_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_hdmi_tx_period_ctrl.sv
// Bench for hdmi_tx_period_ctrl: a default 640x480 instance for line-level timing and a
// small-raster instance for whole-frame behaviour, both checked cycle by cycle plus directed points.
module tb_hdmi_tx_period_ctrl;

    localparam int CW = 12;

    logic pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    logic          rst_a, rst_b, hdmi_a, hdmi_b;
    logic [CW-1:0] h_a, v_a, h_b, v_b;
    logic          de_a, hs_a, vs_a, fs_a, de_b, hs_b, vs_b, fs_b;
    logic [1:0]    mode_a, mode_b;
    logic [3:0]    ctl_a, ctl_b;
    logic [33:0]   obs_a, obs_b;

    assign obs_a = {h_a, v_a, de_a, hs_a, vs_a, mode_a, ctl_a, fs_a};
    assign obs_b = {h_b, v_b, de_b, hs_b, vs_b, mode_b, ctl_b, fs_b};

    hdmi_tx_period_ctrl u_dut_a (
        .pixclk(pixclk), .reset(rst_a), .hdmi_mode(hdmi_a),
        .h_cnt(h_a), .v_cnt(v_a), .de(de_a), .hsync(hs_a), .vsync(vs_a),
        .mode(mode_a), .ctl(ctl_a), .frame_start(fs_a)
    );

    hdmi_tx_period_ctrl #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(12),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CNT_W(CW)
    ) u_dut_b (
        .pixclk(pixclk), .reset(rst_b), .hdmi_mode(hdmi_b),
        .h_cnt(h_b), .v_cnt(v_b), .de(de_b), .hsync(hs_b), .vsync(vs_b),
        .mode(mode_b), .ctl(ctl_b), .frame_start(fs_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit done_a = 1'b0;
    bit done_b = 1'b0;
    int mh[2];
    int mv[2];
    bit ml[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 'h%0h, expected 'h%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int p_ht(input int id);
        return (id == 0) ? 800 : 38;
    endfunction

    function automatic int p_vt(input int id);
        return (id == 0) ? 525 : 13;
    endfunction

    // Expected outputs straight from the raster position, the line's latched HDMI flag and reset.
    function automatic logic [33:0] model(input int id, input int h, input int v, input bit lat, input bit in_rst);
        int ha, hf, hs, va, vf, vs, ht, vt;
        bit hp, vp, de, hact, vact, pre, fs;
        logic [1:0] md;
        logic [3:0] ct;
        if (id == 0) begin
            ha = 640; hf = 16; hs = 96; va = 480; vf = 10; vs = 2; hp = 1'b0; vp = 1'b0;
        end else begin
            ha = 16; hf = 4; hs = 6; va = 6; vf = 2; vs = 2; hp = 1'b1; vp = 1'b0;
        end
        ht = p_ht(id);
        vt = p_vt(id);
        if (in_rst)
            return {12'(ht - 1), 12'(vt - 1), 1'b0, ~hp, ~vp, 2'b00, 4'b0000, 1'b0};
        de   = (h < ha) && (v < va);
        hact = (h >= ha + hf) && (h < ha + hf + hs);
        vact = (v >= va + vf) && (v < va + vf + vs);
        pre  = (v < va - 1) || (v == vt - 1);
        fs   = (h == 0) && (v == 0);
        md   = 2'b00;
        ct   = 4'b0000;
        if (de) md = 2'b11;
        else if (lat && pre && h >= ht - 10 && h <= ht - 3) begin
            md = 2'b01;
            ct = 4'b0001;
        end else if (lat && pre && h >= ht - 2) md = 2'b10;
        return {12'(h), 12'(v), de, hact ? hp : ~hp, vact ? vp : ~vp, md, ct, fs};
    endfunction

    task automatic reset_model(input int id);
        mh[id] = p_ht(id) - 1;
        mv[id] = p_vt(id) - 1;
        ml[id] = 1'b0;
    endtask

    task automatic adv(input int id, input bit hm);
        if (mh[id] == p_ht(id) - 1) begin
            mh[id] = 0;
            ml[id] = hm;
            mv[id] = (mv[id] == p_vt(id) - 1) ? 0 : mv[id] + 1;
        end else begin
            mh[id] = mh[id] + 1;
        end
    endtask

    // One pixel clock: advance the model at the rising edge, compare at the falling edge.
    task automatic step(input int id);
        bit r, hm;
        @(posedge pixclk);
        r  = (id == 0) ? rst_a : rst_b;
        hm = (id == 0) ? hdmi_a : hdmi_b;
        if (r) reset_model(id);
        else adv(id, hm);
        @(negedge pixclk);
        if (id == 0) check("a_cycle", 64'(obs_a), 64'(model(0, mh[0], mv[0], ml[0], rst_a)));
        else         check("b_cycle", 64'(obs_b), 64'(model(1, mh[1], mv[1], ml[1], rst_b)));
    endtask

    task automatic run_to(input int id, input int h, input int v);
        int k;
        k = 0;
        while (!(mh[id] == h && mv[id] == v) && k < 20000) begin
            step(id);
            k++;
        end
        if (k >= 20000) check("run_to_reached", 64'({12'(mh[id]), 12'(mv[id])}), 64'({12'(h), 12'(v)}));
    endtask

    initial begin : proc_a
        int n_de, n_hs, n_fs;
        rst_a  = 1'b1;
        hdmi_a = 1'b1;
        reset_model(0);
        repeat (2) @(negedge pixclk);
        check("a_rst_h", 64'(h_a), 64'd799);
        check("a_rst_v", 64'(v_a), 64'd524);
        check("a_rst_outs", 64'({de_a, hs_a, vs_a, mode_a, ctl_a, fs_a}), 64'(10'b0_1_1_00_0000_0));
        rst_a = 1'b0;
        step(0);
        check("a_first_pos", 64'({h_a, v_a}), 64'd0);
        check("a_first_de_mode_fs", 64'({de_a, mode_a, fs_a}), 64'(4'b1_11_1));
        n_de = int'(de_a);
        n_hs = int'(!hs_a);
        n_fs = int'(fs_a);
        for (int i = 1; i < 800; i++) begin
            step(0);
            n_de += int'(de_a);
            n_hs += int'(!hs_a);
            n_fs += int'(fs_a);
            case (mh[0])
                639: check("a_de_last", 64'(de_a), 64'd1);
                640: check("a_de_fall", 64'(de_a), 64'd0);
                655: check("a_hs_before", 64'(hs_a), 64'd1);
                656: check("a_hs_start", 64'(hs_a), 64'd0);
                751: check("a_hs_end", 64'(hs_a), 64'd0);
                752: check("a_hs_after", 64'(hs_a), 64'd1);
                789: check("a_v0_h789", 64'({mode_a, ctl_a}), 64'(6'b00_0000));
                790: check("a_v0_pre790", 64'({mode_a, ctl_a}), 64'(6'b01_0001));
                797: check("a_v0_pre797", 64'({mode_a, ctl_a}), 64'(6'b01_0001));
                798: check("a_v0_gb798", 64'({mode_a, ctl_a}), 64'(6'b10_0000));
                799: check("a_v0_gb799", 64'({mode_a, ctl_a}), 64'(6'b10_0000));
                default: ;
            endcase
        end
        check("a_de_count", 64'(n_de), 64'd640);
        check("a_hs_count", 64'(n_hs), 64'd96);
        check("a_fs_count", 64'(n_fs), 64'd1);
        step(0);
        check("a_line1_start", 64'({h_a, v_a, de_a, fs_a}), 64'({12'd0, 12'd1, 2'b10}));

        // Drop HDMI mid-line 10: line 10 keeps its preamble, line 11 reverts to control only.
        run_to(0, 300, 10);
        hdmi_a = 1'b0;
        run_to(0, 790, 10);
        check("a_v10_pre", 64'({mode_a, ctl_a}), 64'(6'b01_0001));
        run_to(0, 798, 10);
        check("a_v10_gb", 64'({mode_a, ctl_a}), 64'(6'b10_0000));
        run_to(0, 790, 11);
        check("a_v11_no_pre", 64'({mode_a, ctl_a}), 64'(6'b00_0000));
        run_to(0, 798, 11);
        check("a_v11_no_gb", 64'({mode_a, ctl_a}), 64'(6'b00_0000));

        run_to(0, 100, 12);
        #2 rst_a = 1'b1;
        #1 check("a_async_rst", 64'(obs_a), 64'({12'd799, 12'd524, 10'b0_1_1_00_0000_0}));
        reset_model(0);
        @(negedge pixclk);
        step(0);
        rst_a  = 1'b0;
        hdmi_a = 1'b1;
        step(0);
        check("a_restart", 64'({h_a, v_a, de_a, mode_a, fs_a}), 64'({12'd0, 12'd0, 4'b1_11_1}));
        repeat (20) step(0);
        done_a = 1'b1;
    end

    initial begin : proc_b
        int last_fs, n_fs;
        rst_b  = 1'b1;
        hdmi_b = 1'b1;
        reset_model(1);
        repeat (2) @(negedge pixclk);
        check("b_rst_outs", 64'(obs_b), 64'({12'd37, 12'd12, 10'b0_0_1_00_0000_0}));
        rst_b   = 1'b0;
        last_fs = -1;
        n_fs    = 0;
        for (int cyc = 0; cyc < 3 * 494; cyc++) begin
            if (cyc == 600)  hdmi_b = 1'b0;
            if (cyc == 1000) hdmi_b = 1'b1;
            step(1);
            if (fs_b) begin
                if (last_fs >= 0) check("b_fs_spacing", 64'(cyc - last_fs), 64'd494);
                last_fs = cyc;
                n_fs++;
            end
            if (cyc < 494) begin
                if (mv[1] == 5 && mh[1] >= 16) check("b_v5_blank_ctrl", 64'(mode_b), 64'd0);
                if (mv[1] == 12 && mh[1] == 28) check("b_v12_pre", 64'({mode_b, ctl_b}), 64'(6'b01_0001));
                if (mv[1] == 12 && mh[1] == 36) check("b_v12_gb", 64'({mode_b, ctl_b}), 64'(6'b10_0000));
                if (mv[1] == 0 && mh[1] == 19) check("b_hs_before", 64'(hs_b), 64'd0);
                if (mv[1] == 0 && mh[1] == 20) check("b_hs_start", 64'(hs_b), 64'd1);
                if (mh[1] == 0) check("b_vsync", 64'(vs_b), (mv[1] == 8 || mv[1] == 9) ? 64'd0 : 64'd1);
            end
        end
        check("b_fs_count", 64'(n_fs), 64'd3);
        done_b = 1'b1;
    end

    initial begin : proc_end
        int t;
        t = 0;
        while (!(done_a && done_b) && t < 200000) begin
            @(posedge pixclk);
            t++;
        end
        if (!(done_a && done_b)) check("watchdog_done", 64'({done_a, done_b}), 64'(2'b11));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
